vga_rd_prefetch: RTL and testbench

Read-side prefetch stage sitting directly upstream of the VGA display engine. It issues fixed-length burst read requests to the DDR read port, buffers the returned 64-bit words (four RGB565 pixels each) in a first-word-fall-through FIFO, and presents the head word on `ddr_data` for the display engine to consume with its `ddr_rden` pop strobe. At each frame start it flushes stale data, drops any in-flight beats and restarts reading from the frame base address.

---
 rtl/vga_rd_prefetch.sv | 139 +++++++++++++
 tb/tb_vga_rd_prefetch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rd_prefetch.sv
// vga_rd_prefetch: DDR burst prefetch feeding a FWFT FIFO for the VGA engine.
// Define VGA_RD_PREFETCH_STATS_EN to build the saturating underflow counter.
module vga_rd_prefetch #(
  parameter int ADDR_W      = 28,
  parameter int FRAME_BASE  = 0,
  parameter int FRAME_WORDS = 230400,
  parameter int BURST_LEN   = 64,
  parameter int FIFO_AW     = 8
) (
  input  logic              vga_clk,
  input  logic              vga_rst_n,
  input  logic              ddr_init_done,
  input  logic              frame_start,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_data_valid,
  input  logic [63:0]       rd_data,
  input  logic              ddr_rden,
  output logic [63:0]       ddr_data,
  output logic [FIFO_AW:0]  fifo_level,
  output logic              underflow,
  output logic [15:0]       underflow_cnt
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 2;
  localparam int RW    = $clog2(FRAME_WORDS + 1);

  localparam logic [CW-1:0]     BL_C    = CW'(BURST_LEN);
  localparam logic [CW-1:0]     LIMIT   = CW'(DEPTH - BURST_LEN);
  localparam logic [RW-1:0]     BL_R    = RW'(BURST_LEN);
  localparam logic [RW-1:0]     FRAME_W = RW'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] BL_A    = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(FRAME_BASE);
  localparam logic [FIFO_AW:0]  FULL    = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, DONE, FLUSH} state_t;

  state_t              state;
  logic [63:0]         mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
  logic [FIFO_AW:0]    lvl_n;
  logic [CW-1:0]       outst, out_n;
  logic [RW-1:0]       req_words, req_n;
  logic                flushing, ack, wr_en, rd_adv;
  logic                uf_n, beat_dec, eligible;

  assign flushing = (state == FLUSH);
  assign ack      = rd_req & rd_ack;
  assign wr_en    = rd_data_valid & ~flushing &
                    ((fifo_level != FULL) |
                     (ddr_rden & (fifo_level != '0)));
  // a pop on empty with a same-cycle push consumes the pushed word
  assign rd_adv   = ddr_rden & ((fifo_level != '0) | wr_en);
  assign uf_n     = ddr_rden & (fifo_level == '0);
  assign lvl_n    = fifo_level + (FIFO_AW+1)'(wr_en)
                  - (FIFO_AW+1)'(rd_adv);

  assign beat_dec = rd_data_valid & (outst != '0);
  assign out_n    = outst + (ack ? BL_C : '0) - CW'(beat_dec);
  assign req_n    = req_words + (ack ? BL_R : '0);
  // credit counts words in the FIFO plus words already requested
  assign eligible = ddr_init_done &
                    ((CW'(lvl_n) + out_n) <= LIMIT) &
                    (req_n < FRAME_W);

  always_ff @(posedge vga_clk)
    if (wr_en) mem[wr_ptr] <= rd_data;

  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      state     <= IDLE;
      rd_req    <= 1'b0;
      rd_addr   <= BASE_A;
      outst     <= '0;
      req_words <= '0;
    end else begin
      outst  <= out_n;
      rd_req <= 1'b0;
      unique case (state)
        IDLE:
          if (frame_start && ddr_init_done) state <= FLUSH;
        FILL, DONE: begin
          if (ack) begin
            rd_addr   <= rd_addr + BL_A;
            req_words <= req_n;
          end
          if (frame_start)            state <= FLUSH;
          else if (req_n == FRAME_W)  state <= DONE;
          else rd_req <= (rd_req & ~rd_ack) | eligible;
        end
        FLUSH:
          if (out_n == '0) begin
            state     <= FILL;
            rd_addr   <= BASE_A;
            req_words <= '0;
          end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ddr_data   <= '0;
      underflow  <= 1'b0;
    end else begin
      underflow <= uf_n;
      ddr_data  <= (fifo_level != '0 && !flushing) ? mem[rd_ptr] : '0;
      if (flushing) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_level <= '0;
      end else begin
        if (wr_en)  wr_ptr <= wr_ptr + FIFO_AW'(1);
        if (rd_adv) rd_ptr <= rd_ptr + FIFO_AW'(1);
        fifo_level <= lvl_n;
      end
    end
  end

`ifdef VGA_RD_PREFETCH_STATS_EN
  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n)
      underflow_cnt <= '0;
    else if (frame_start)
      underflow_cnt <= '0;
    else if (uf_n && underflow_cnt != 16'hFFFF)
      underflow_cnt <= underflow_cnt + 16'd1;
  end
`else
  assign underflow_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_rd_prefetch.sv
// tb_vga_rd_prefetch: vector table, directed frame sequences and random
// traffic checked against a queue model of the prefetcher.
module tb_vga_rd_prefetch;
  localparam int AW = 28, FW = 1024, BL = 64, FAW = 8, DEPTH = 256;
`ifdef VGA_RD_PREFETCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          vga_clk = 1'b0;
  logic          vga_rst_n, ddr_init_done, frame_start;
  logic          rd_req, rd_ack, rd_data_valid, ddr_rden, underflow;
  logic [AW-1:0] rd_addr;
  logic [63:0]   rd_data, ddr_data;
  logic [FAW:0]  fifo_level;
  logic [15:0]   underflow_cnt;

  always #5 vga_clk = ~vga_clk;

  vga_rd_prefetch #(
    .ADDR_W(AW), .FRAME_BASE(0), .FRAME_WORDS(FW),
    .BURST_LEN(BL), .FIFO_AW(FAW)
  ) dut (
    .vga_clk(vga_clk), .vga_rst_n(vga_rst_n),
    .ddr_init_done(ddr_init_done), .frame_start(frame_start),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .ddr_rden(ddr_rden), .ddr_data(ddr_data),
    .fifo_level(fifo_level), .underflow(underflow),
    .underflow_cnt(underflow_cnt)
  );

  typedef struct { int t; logic [63:0] d; } beat_t;
  typedef struct {
    bit push; logic [63:0] d; bit pop;
    int lvl; logic [63:0] data; bit uf; int cnt;
  } vec_t;

  beat_t         pend[$];
  logic [63:0]   q[$];
  vec_t          tbl[17];
  int            outst, nreq, cyc, checks, failures;
  int            nbeats, dut_uf, e_cnt, ack_pct, lat;
  logic [AW-1:0] exp_addr, last_ack_addr;
  bit            started, flushing;
  bit            k_fs, k_rden, k_beat_en, k_force;
  logic [63:0]   k_fdata;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // one clock: drive at negedge, predict, compare at next negedge
  task automatic step();
    bit ack, beat, fl0, e_uf;
    logic [63:0] bd, e_data;
    int sz;
    ack  = rd_req && ($urandom_range(1, 100) <= ack_pct);
    beat = 1'b0;
    bd   = '0;
    if (k_force) begin
      beat = 1'b1;
      bd   = k_fdata;
    end else if (k_beat_en && pend.size() > 0 && pend[0].t <= cyc) begin
      beat = 1'b1;
      bd   = pend[0].d;
      void'(pend.pop_front());
    end
    frame_start   = k_fs;
    ddr_rden      = k_rden;
    rd_ack        = ack;
    rd_data_valid = beat;
    rd_data       = beat ? bd : '0;
    if (beat) nbeats++;

    if (flushing || !started) chk("req_quiet", rd_req, 0);
    if (ack) begin
      chk("req_addr", rd_addr, exp_addr);
      chk("req_credit", rd_req, (q.size() + outst) <= DEPTH - BL);
      chk("req_count", rd_req, nreq < FW / BL);
      for (int i = 0; i < BL; i++)
        pend.push_back('{cyc + lat + i, 64'(exp_addr) + 64'(i)});
      last_ack_addr = rd_addr;
      outst    += BL;
      exp_addr += AW'(BL);
      nreq++;
    end

    fl0    = flushing;
    sz     = q.size();
    e_uf   = k_rden && sz == 0;
    e_data = (!fl0 && sz > 0) ? q[0] : '0;
    if (beat && outst > 0) outst--;
    if (fl0) begin
      q.delete();
      if (outst == 0) begin
        flushing = 1'b0;
        exp_addr = '0;
        nreq     = 0;
      end
    end else begin
      if (beat) q.push_back(bd);
      if (k_rden && (sz > 0 || beat)) void'(q.pop_front());
    end
    if (k_fs) begin
      e_cnt = 0;
      if (!fl0 && (started || ddr_init_done)) begin
        started  = 1'b1;
        flushing = 1'b1;
      end
    end else if (e_uf && e_cnt < 65535) e_cnt++;

    @(posedge vga_clk);
    cyc++;
    @(negedge vga_clk);
    if (underflow) dut_uf++;
    chk("ddr_data", ddr_data, e_data);
    chk("fifo_level", fifo_level, q.size());
    chk("underflow", underflow, e_uf);
    chk("underflow_cnt", underflow_cnt, STATS ? e_cnt : 0);
  endtask

  task automatic do_reset();
    vga_rst_n = 1'b0;
    frame_start = 0; ddr_rden = 0; rd_ack = 0;
    rd_data_valid = 0; rd_data = '0;
    pend.delete(); q.delete();
    outst = 0; nreq = 0; exp_addr = '0; e_cnt = 0;
    started = 0; flushing = 0;
    k_fs = 0; k_rden = 0; k_beat_en = 0; k_force = 0;
    repeat (2) @(negedge vga_clk);
    chk("rst_req", rd_req, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_data", ddr_data, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_uf", underflow, 0);
    chk("rst_cnt", underflow_cnt, 0);
    vga_rst_n = 1'b1;
    @(negedge vga_clk);
  endtask

  initial begin
    bit popping;
    int popped;
    tbl[0]  = '{0, 64'h0, 1, 0, 64'h0, 1, 1};
    tbl[1]  = '{0, 64'h0, 1, 0, 64'h0, 1, 2};
    tbl[2]  = '{0, 64'h0, 1, 0, 64'h0, 1, 3};
    tbl[3]  = '{1, 64'hA1, 0, 1, 64'h0, 0, 3};
    tbl[4]  = '{0, 64'h0, 0, 1, 64'hA1, 0, 3};
    tbl[5]  = '{1, 64'hA2, 1, 1, 64'hA1, 0, 3};
    tbl[6]  = '{0, 64'h0, 0, 1, 64'hA2, 0, 3};
    tbl[7]  = '{1, 64'hA3, 1, 1, 64'hA2, 0, 3};
    tbl[8]  = '{0, 64'h0, 1, 0, 64'hA3, 0, 3};
    tbl[9]  = '{1, 64'hA4, 1, 0, 64'h0, 1, 4};
    tbl[10] = '{0, 64'h0, 0, 0, 64'h0, 0, 4};
    tbl[11] = '{1, 64'hA5, 0, 1, 64'h0, 0, 4};
    tbl[12] = '{1, 64'hA6, 0, 2, 64'hA5, 0, 4};
    tbl[13] = '{0, 64'h0, 1, 1, 64'hA5, 0, 4};
    tbl[14] = '{0, 64'h0, 0, 1, 64'hA6, 0, 4};
    tbl[15] = '{0, 64'h0, 1, 0, 64'hA6, 0, 4};
    tbl[16] = '{0, 64'h0, 0, 0, 64'h0, 0, 4};
    checks = 0; failures = 0; cyc = 0; nbeats = 0; dut_uf = 0;
    ack_pct = 100; lat = 2; ddr_init_done = 1'b0;
    last_ack_addr = '0;

    // FIFO vectors while idle: underflow, push/pop at level 0 and 1
    do_reset();
    foreach (tbl[i]) begin
      k_force = tbl[i].push;
      k_fdata = tbl[i].d;
      k_rden  = tbl[i].pop;
      step();
      chk("tv_level", fifo_level, tbl[i].lvl);
      chk("tv_data", ddr_data, tbl[i].data);
      chk("tv_uf", underflow, tbl[i].uf);
      chk("tv_cnt", underflow_cnt, STATS ? tbl[i].cnt : 0);
    end
    k_force = 0; k_rden = 0;

    // credit limit: four bursts with no data returned
    do_reset();
    ddr_init_done = 1'b1;
    k_fs = 1; step(); k_fs = 0;
    repeat (30) step();
    chk("nopop_reqs", nreq, 4);
    chk("nopop_last_addr", last_ack_addr, 192);

    // 64 beats in, then four pops
    k_beat_en = 1;
    for (int i = 0; i < 500 && q.size() < 64; i++) step();
    k_beat_en = 0;
    step();
    chk("fill_level", fifo_level, 64);
    chk("fill_head", ddr_data, 0);
    k_rden = 1; repeat (4) step(); k_rden = 0;
    step();
    chk("pop4_head", ddr_data, 4);
    chk("pop4_level", fifo_level, 60);

    // frame start with 40 beats in flight
    k_beat_en = 1;
    for (int i = 0; i < 400 && outst > 40; i++) step();
    k_beat_en = 0;
    k_fs = 1; step(); k_fs = 0;
    nbeats = 0;
    k_beat_en = 1;
    for (int i = 0; i < 400 && !rd_req; i++) step();
    chk("flush_req_seen", rd_req, 1);
    chk("flush_beats_first", nbeats, 40);
    chk("flush_restart_addr", rd_addr, 0);
    chk("flush_level", fifo_level, 0);

    // whole frame, latency 20, one pop per 4 cycles once primed
    do_reset();
    ddr_init_done = 1'b1; lat = 20; ack_pct = 100; k_beat_en = 1;
    k_fs = 1; step(); k_fs = 0;
    popping = 0; popped = 0; dut_uf = 0;
    for (int i = 0; i < 20000 && !(popped == FW && nreq == FW / BL); i++) begin
      if (q.size() >= 128) popping = 1;
      k_rden = popping && popped < FW && (i % 4 == 0);
      if (k_rden) popped++;
      step();
    end
    k_rden = 0;
    repeat (40) step();
    chk("frame_pops", popped, FW);
    chk("frame_underflows", dut_uf, 0);
    chk("frame_reqs", nreq, FW / BL);
    chk("frame_last_addr", last_ack_addr, FW - BL);
    chk("frame_done_req", rd_req, 0);

    // random traffic against the model
    do_reset();
    ddr_init_done = 1'b1; ack_pct = 60; lat = 5;
    k_fs = 1; step(); k_fs = 0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 99) == 0) lat = $urandom_range(1, 30);
      if ($urandom_range(0, 499) == 0) ddr_init_done = ~ddr_init_done;
      k_beat_en = $urandom_range(0, 9) < 8;
      k_rden    = $urandom_range(0, 9) < 3;
      k_fs      = $urandom_range(0, 399) == 0;
      step();
    end
    k_fs = 0; k_rden = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
